pipe_issue_ctrl: RTL and testbench

//  Issue/run controller for the 4-stage 16-bit pipeline (format [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm).

---
 rtl/pipe_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_ctrl.sv
// Issue/run controller between IF_ID and ID_EX of the 4-stage 16-bit pipeline.
// A per-register countdown scoreboard holds back RAW hazards; a small FSM handles run/halt/step.
module pipe_issue_ctrl #(
  parameter int NREGS  = 8,
  parameter int WB_LAT = 3,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              step,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  output logic              fetch_en,
  output logic              issue,
  output logic              bubble,
  output logic [NREGS-1:0]  busy_mask,
  output logic [2:0]        state,
  output logic              halted,
  output logic [SCNT_W-1:0] stall_count
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CW = $clog2(WB_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q [NREGS];
  logic [CW-1:0]     cnt_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              halted_q, halted_d;

  logic [3:0]    op;
  logic [IW-1:0] rd, rs1, rs2;
  logic          wr_rd, rd_rs1, rd_rs2, hazard, active;
  logic          unused_ok;

  // Register fields wider than the index are masked to their low bits.
  assign op        = id_instr[15:12];
  assign rd        = id_instr[8 +: IW];
  assign rs1       = id_instr[4 +: IW];
  assign rs2       = id_instr[0 +: IW];
  assign unused_ok = ^id_instr;

  always_comb begin
    wr_rd    = (op >= 4'd1) && (op <= 4'd4);
    rd_rs1   = wr_rd;
    rd_rs2   = (op >= 4'd1) && (op <= 4'd3);
    hazard   = id_valid && ((rd_rs1 && busy_q[rs1]) || (rd_rs2 && busy_q[rs2]));
    active   = (state_q == S_RUN) || (state_q == S_STEP);
    issue    = active && id_valid && !hazard;
    fetch_en = ((state_q == S_RUN) && !hazard) || ((state_q == S_STEP) && issue);
    bubble   = !issue;
  end

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      // A fresh load wins over this register's own decrement in the same cycle.
      if (issue && wr_rd && (rd == IW'(r))) begin
        cnt_d[r] = CW'(WB_LAT);
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (active && hazard && (scnt_q != '1)) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  // halt_req outranks start and step in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (halt_req)   state_d = S_DRAIN;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_req) state_d = S_DRAIN;
      end
      S_STEP: begin
        if (halt_req || issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (busy_q == '0) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (halt_req)   state_d = S_DRAIN;
        else if (start) state_d = S_RUN;
        else if (step)  state_d = S_STEP;
      end
      default: state_d = S_IDLE;
    endcase
    halted_d = (state_d == S_HALTED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= '0;
      scnt_q   <= '0;
      halted_q <= 1'b0;
      // NOTE: the scoreboard array is reset on purpose; stale counts after reset would stall fresh code.
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      scnt_q   <= scnt_d;
      halted_q <= halted_d;
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign busy_mask   = busy_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign stall_count = scnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: directed scenarios plus random traffic,
// each cycle compared against a timestamp-based reference model of the issue rules.
module tb_pipe_issue_ctrl;

  localparam int NREGS  = 8;
  localparam int WB_LAT = 3;
  localparam int SCNT_W = 16;

  logic              clk = 1'b0;
  logic              reset, start, halt_req, step, id_valid;
  logic [15:0]       id_instr;
  logic              fetch_en, issue, bubble, halted;
  logic [NREGS-1:0]  busy_mask;
  logic [2:0]        state;
  logic [SCNT_W-1:0] stall_count;

  pipe_issue_ctrl #(.NREGS(NREGS), .WB_LAT(WB_LAT), .SCNT_W(SCNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .step(step),
    .id_valid(id_valid), .id_instr(id_instr), .fetch_en(fetch_en), .issue(issue),
    .bubble(bubble), .busy_mask(busy_mask), .state(state), .halted(halted),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a register is busy in the WB_LAT cycles after the cycle it was issued in.
  int          m_state = 0;
  int          m_stall = 0;
  longint      m_cyc = 0;
  longint      m_last [NREGS];
  bit          chk_en = 1'b0;
  bit          if_valid = 1'b0;
  logic [15:0] if_instr = 16'h0000;
  logic [15:0] prog [$];

  logic [2:0]        obs_state;
  logic              obs_issue, obs_fe, obs_bubble, obs_halted;
  logic [NREGS-1:0]  obs_busy;
  logic [SCNT_W-1:0] obs_stall;

  function automatic logic [NREGS-1:0] m_busy();
    logic [NREGS-1:0] b = '0;
    for (int r = 0; r < NREGS; r++)
      b[r] = (m_cyc > m_last[r]) && (m_cyc <= m_last[r] + WB_LAT);
    return b;
  endfunction

  task automatic model_clear();
    m_state = 0;
    m_stall = 0;
    for (int r = 0; r < NREGS; r++) m_last[r] = -100;
    if_valid = 1'b0;
    prog.delete();
  endtask

  // One clock cycle: drive inputs, compare all outputs to the model, then advance model and IF_ID.
  task automatic run_cycle(input logic rst, input logic st, input logic hr, input logic sp);
    logic [NREGS-1:0] b;
    int op, rd, rs1, rs2, nxt;
    bit wr, rd2, hz, act, iss, fe;
    @(negedge clk);
    reset = rst; start = st; halt_req = hr; step = sp;
    id_valid = if_valid; id_instr = if_instr;
    #1;
    b   = m_busy();
    op  = int'(if_instr[15:12]);
    rd  = int'(if_instr[11:8]) % NREGS;
    rs1 = int'(if_instr[7:4]) % NREGS;
    rs2 = int'(if_instr[3:0]) % NREGS;
    wr  = (op >= 1) && (op <= 4);
    rd2 = (op >= 1) && (op <= 3);
    hz  = if_valid && ((wr && b[rs1]) || (rd2 && b[rs2]));
    act = (m_state == 1) || (m_state == 2);
    iss = act && if_valid && !hz;
    fe  = ((m_state == 1) && !hz) || ((m_state == 2) && iss);
    obs_state = state; obs_issue = issue; obs_fe = fetch_en; obs_bubble = bubble;
    obs_halted = halted; obs_busy = busy_mask; obs_stall = stall_count;
    if (chk_en) begin
      checks++;
      if (obs_state !== 3'(m_state)) begin
        errors++; $display("FAIL model_state cyc=%0d: got %0d expected %0d", m_cyc, obs_state, m_state);
      end
      checks++;
      if (obs_halted !== (m_state == 4)) begin
        errors++; $display("FAIL model_halted cyc=%0d: got %b expected %b", m_cyc, obs_halted, m_state == 4);
      end
      checks++;
      if (obs_busy !== b) begin
        errors++; $display("FAIL model_busy cyc=%0d: got %h expected %h", m_cyc, obs_busy, b);
      end
      checks++;
      if (obs_stall !== SCNT_W'(m_stall)) begin
        errors++; $display("FAIL model_stall cyc=%0d: got %0d expected %0d", m_cyc, obs_stall, m_stall);
      end
      checks++;
      if (obs_issue !== iss) begin
        errors++; $display("FAIL model_issue cyc=%0d: got %b expected %b", m_cyc, obs_issue, iss);
      end
      checks++;
      if (obs_fe !== fe) begin
        errors++; $display("FAIL model_fetch cyc=%0d: got %b expected %b", m_cyc, obs_fe, fe);
      end
      checks++;
      if (obs_bubble !== !iss) begin
        errors++; $display("FAIL model_bubble cyc=%0d: got %b expected %b", m_cyc, obs_bubble, !iss);
      end
    end
    nxt = m_state;
    case (m_state)
      0: if (hr) nxt = 3; else if (st) nxt = 1;
      1: if (hr) nxt = 3;
      2: if (hr || iss) nxt = 3;
      3: if (b == '0) nxt = 4;
      4: if (hr) nxt = 3; else if (st) nxt = 1; else if (sp) nxt = 2;
      default: nxt = 0;
    endcase
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (iss && wr) m_last[rd] = m_cyc;
      if (act && hz && m_stall < (2 ** SCNT_W - 1)) m_stall++;
      m_state = nxt;
      if (fe) begin
        if (prog.size() > 0) begin
          if_instr = prog.pop_front();
          if_valid = 1'b1;
        end else begin
          if_valid = 1'b0;
        end
      end
    end
    m_cyc++;
  endtask

  task automatic test_reset();
    model_clear();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_state !== 3'd0 || obs_fe !== 1'b0 || obs_bubble !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got state=%0d fetch=%b bubble=%b expected 0/0/1", obs_state, obs_fe, obs_bubble);
    end
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_state !== 3'd1 || obs_fe !== 1'b1) begin
      errors++; $display("FAIL start_run: got state=%0d fetch=%b expected 1/1", obs_state, obs_fe);
    end
  endtask

  task automatic test_raw_stall();
    prog.push_back(16'h1121);
    prog.push_back(16'h2312);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_issue !== 1'b1) begin
      errors++; $display("FAIL raw_writer_issue: got %b expected 1", obs_issue);
    end
    for (int k = 1; k <= WB_LAT; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_fe !== 1'b0 || obs_bubble !== 1'b1) begin
        errors++; $display("FAIL raw_stall_%0d: got fetch=%b bubble=%b expected 0/1", k, obs_fe, obs_bubble);
      end
      if (k == 1) begin
        checks++;
        if (obs_busy !== 8'h02) begin
          errors++; $display("FAIL raw_busy: got %h expected 02", obs_busy);
        end
      end
    end
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_issue !== 1'b1) begin
      errors++; $display("FAIL raw_dependent_issue: got %b expected 1", obs_issue);
    end
    checks++;
    if (obs_stall !== 16'd3) begin
      errors++; $display("FAIL raw_stall_count: got %0d expected 3", obs_stall);
    end
    repeat (5) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_no_stall();
    prog.push_back(16'h2312);
    prog.push_back(16'h4503);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_issue !== 1'b1 || obs_busy[3] !== 1'b1) begin
      errors++; $display("FAIL load_issue: got issue=%b busy3=%b expected 1/1", obs_issue, obs_busy[3]);
    end
    for (int k = 1; k <= WB_LAT + 1; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_busy[5] !== (k <= WB_LAT)) begin
        errors++; $display("FAIL load_busy_%0d: got %b expected %b", k, obs_busy[5], k <= WB_LAT);
      end
    end
  endtask

  task automatic test_halt_drain();
    bit done = 1'b0;
    prog.push_back(16'h1121);
    prog.push_back(16'h1121);
    prog.push_back(16'h2312);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12 && !done; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_fe !== 1'b0 || obs_issue !== 1'b0) begin
        errors++; $display("FAIL drain_quiet: got fetch=%b issue=%b expected 0/0", obs_fe, obs_issue);
      end
      if (obs_state === 3'd4) done = 1'b1;
    end
    checks++;
    if (!done || obs_halted !== 1'b1 || obs_busy !== '0) begin
      errors++; $display("FAIL drain_halted: got done=%b halted=%b busy=%h expected 1/1/00", done, obs_halted, obs_busy);
    end
  endtask

  task automatic test_single_step();
    int  issues = 0;
    bit  done = 1'b0;
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    if (obs_issue === 1'b1) issues++;
    for (int k = 0; k < 12 && !done; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (obs_issue === 1'b1) issues++;
      if (k > 0 && obs_state === 3'd4) done = 1'b1;
    end
    repeat (4) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (obs_issue === 1'b1) issues++;
    end
    checks++;
    if (issues != 1 || !done) begin
      errors++; $display("FAIL step_once: got issues=%0d rehalted=%b expected 1/1", issues, done);
    end
  endtask

  task automatic test_reset_mid_stall();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    prog.push_back(16'h1121);
    prog.push_back(16'h2312);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_state !== 3'd0 || obs_busy !== '0 || obs_stall !== '0 || obs_issue !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall: got state=%0d busy=%h stall=%0d issue=%b expected 0/00/0/0",
                         obs_state, obs_busy, obs_stall, obs_issue);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 800; n++) begin
      while (prog.size() < 2) begin
        w = 16'($urandom);
        w[15:12] = 4'($urandom_range(0, 6));
        prog.push_back(w);
      end
      run_cycle(1'($urandom_range(0, 249) == 0), 1'($urandom_range(0, 11) == 0),
                1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; step = 1'b0;
    id_valid = 1'b0; id_instr = 16'h0000;
    test_reset();
    test_raw_stall();
    test_load_no_stall();
    test_halt_drain();
    test_single_step();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
